fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests a word at the current PC, holds it for
// decode, pulses the PC advance and raises a sticky error on memory timeout.
module fetch_unit #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_pc,
   output logic        o_incPc,
   output logic [7:0]  o_memAddr,
   output logic        o_memRd,
   input  logic [15:0] i_memData,
   input  logic        i_memAck,
   output logic [15:0] o_instr,
   output logic        o_instrValid,
   input  logic        i_decReady,
   input  logic        i_flush,
   output logic        o_fetchErr,
   output logic [7:0]  o_fetchCount
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      ADVANCE,
      SETTLE,
      ERR
   } state_t;

   localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [3:0]  tmo_cnt, tmo_cnt_nx;
   logic        inc_pc_nx, mem_rd_nx, instr_valid_nx, fetch_err_nx;
   logic [7:0]  mem_addr_nx, fetch_count_nx;
   logic [15:0] instr_nx;
   logic        tmo_hit;

   // Counter holds the number of ack-less REQ cycles already completed.
   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = REQ;
         REQ: begin
            if (i_flush)       state_nx = IDLE;
            else if (i_memAck) state_nx = HOLD;
            else if (tmo_hit)  state_nx = ERR;
         end
         HOLD: begin
            if (i_flush)         state_nx = IDLE;
            else if (i_decReady) state_nx = ADVANCE;
         end
         ADVANCE: state_nx = i_flush ? IDLE : SETTLE;
         SETTLE:  state_nx = i_flush ? IDLE : REQ;
         ERR:     state_nx = ERR;
         default: state_nx = IDLE;
      endcase
   end

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      mem_addr_nx    = o_memAddr;
      instr_nx       = o_instr;
      fetch_count_nx = o_fetchCount;
      tmo_cnt_nx     = tmo_cnt;
      mem_rd_nx      = (state_nx == REQ);
      inc_pc_nx      = (state_nx == ADVANCE);
      instr_valid_nx = (state_nx == HOLD);
      fetch_err_nx   = (state_nx == ERR);
      if ((state_nx == REQ) && (state != REQ)) begin
         mem_addr_nx = i_pc;
         tmo_cnt_nx  = '0;
      end else if ((state == REQ) && (state_nx == REQ)) begin
         tmo_cnt_nx = tmo_cnt + 4'd1;
      end
      if ((state == REQ) && (state_nx == HOLD)) begin
         instr_nx = i_memData;
      end
      if ((state == HOLD) && (state_nx == ADVANCE)) begin
         fetch_count_nx = o_fetchCount + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_incPc      <= 1'b0;
         o_memRd      <= 1'b0;
         o_memAddr    <= '0;
         o_instr      <= '0;
         o_instrValid <= 1'b0;
         o_fetchErr   <= 1'b0;
         o_fetchCount <= '0;
         tmo_cnt      <= '0;
      end else begin
         o_incPc      <= inc_pc_nx;
         o_memRd      <= mem_rd_nx;
         o_memAddr    <= mem_addr_nx;
         o_instr      <= instr_nx;
         o_instrValid <= instr_valid_nx;
         o_fetchErr   <= fetch_err_nx;
         o_fetchCount <= fetch_count_nx;
         tmo_cnt      <= tmo_cnt_nx;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder and PC register models, program-order
// scoreboard, directed fetch/back-pressure/flush/reset/timeout sequences.
module tb_fetch_unit;

   localparam int unsigned TMO = 3;

   logic        clk          = 1'b0;
   logic        i_reset      = 1'b0;
   logic [7:0]  i_pc         = '0;
   logic        i_memAck     = 1'b0;
   logic [15:0] i_memData    = '0;
   logic        i_decReady   = 1'b0;
   logic        i_flush      = 1'b0;
   logic        o_incPc, o_memRd, o_instrValid, o_fetchErr;
   logic [7:0]  o_memAddr, o_fetchCount;
   logic [15:0] o_instr;

   fetch_unit #(.MEM_TIMEOUT(TMO)) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_pc         (i_pc),
      .o_incPc      (o_incPc),
      .o_memAddr    (o_memAddr),
      .o_memRd      (o_memRd),
      .i_memData    (i_memData),
      .i_memAck     (i_memAck),
      .o_instr      (o_instr),
      .o_instrValid (o_instrValid),
      .i_decReady   (i_decReady),
      .i_flush      (i_flush),
      .o_fetchErr   (o_fetchErr),
      .o_fetchCount (o_fetchCount)
   );

   always #5 clk = ~clk;

   int          n_checks  = 0;
   int          n_pass    = 0;
   logic [15:0] mem [256];
   logic [15:0] sb_q [$];
   int          lat_mode  = 0;
   bit          ack_en    = 1'b1;
   logic [7:0]  redir_val = '0;
   int          redir_seq = 0;
   int          acc_total = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   // PC change from outside: PC register is loaded and the expected stream restarts there.
   task automatic redirect(input logic [7:0] pc);
      redir_val = pc;
      redir_seq++;
   endtask

   initial begin : pc_reg
      int seen;
      seen = 0;
      forever begin
         @(negedge clk);
         if (redir_seq != seen) begin
            seen = redir_seq;
            i_pc = redir_val;
         end else if (o_incPc) begin
            i_pc = i_pc + 8'd1;
         end
      end
   end

   initial begin : mem_model
      int         seen, rd_cycles, cur_lat;
      logic [7:0] exp_pc;
      seen = 0; rd_cycles = 0; cur_lat = 0; exp_pc = '0;
      forever begin
         @(negedge clk);
         if (redir_seq != seen) begin
            seen   = redir_seq;
            exp_pc = redir_val;
         end
         i_memAck  = 1'b0;
         i_memData = 16'($urandom);
         if (i_reset) begin
            rd_cycles = 0;
         end else if (o_memRd) begin
            if (rd_cycles == 0)
               cur_lat = (lat_mode < 0) ? int'($urandom_range(TMO - 1, 0)) : lat_mode;
            if (ack_en && rd_cycles == cur_lat) begin
               i_memAck  = 1'b1;
               i_memData = mem[o_memAddr];
               if (!i_flush) begin
                  sb_q.push_back(mem[exp_pc]);
                  exp_pc = exp_pc + 8'd1;
               end
            end
            rd_cycles++;
         end else begin
            rd_cycles = 0;
            i_memAck  = ($urandom_range(3, 0) == 0);
         end
      end
   end

   logic        mon_prev_valid = 1'b0;
   logic        mon_pending    = 1'b0;
   logic [7:0]  mon_exp_count  = '0;
   logic [15:0] mon_exp_instr  = '0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (i_reset) begin
            mon_prev_valid = 1'b0;
            mon_pending    = 1'b0;
            mon_exp_count  = '0;
            sb_q.delete();
         end else begin
            if (mon_pending) begin
               chk("accept_incPc", 32'(o_incPc), 32'd1);
               chk("accept_valid_drop", 32'(o_instrValid), 32'd0);
            end else begin
               chk("no_incPc", 32'(o_incPc), 32'd0);
            end
            chk("fetchCount", 32'(o_fetchCount), 32'(mon_exp_count));
            if (o_instrValid && !mon_prev_valid) begin
               chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
               if (sb_q.size() != 0) begin
                  mon_exp_instr = sb_q.pop_front();
                  chk("instr", 32'(o_instr), 32'(mon_exp_instr));
               end
            end else if (o_instrValid) begin
               chk("instr_stable", 32'(o_instr), 32'(mon_exp_instr));
            end
            mon_prev_valid = o_instrValid;
            mon_pending    = o_instrValid && i_decReady && !i_flush;
            if (mon_pending) begin
               mon_exp_count = mon_exp_count + 8'd1;
               acc_total++;
            end
         end
      end
   end

   initial begin : main
      int w, rd_hi, cyc;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h10] = 16'hABCD;
      i_reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_incPc", 32'(o_incPc), 32'd0);
      chk("rst_memRd", 32'(o_memRd), 32'd0);
      chk("rst_memAddr", 32'(o_memAddr), 32'd0);
      chk("rst_instr", 32'(o_instr), 32'd0);
      chk("rst_valid", 32'(o_instrValid), 32'd0);
      chk("rst_err", 32'(o_fetchErr), 32'd0);
      chk("rst_count", 32'(o_fetchCount), 32'd0);
      redirect(8'h10);
      lat_mode   = 0;
      i_decReady = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;

      // Basic fetch at 0x10 with immediate ack and ready decode.
      @(posedge clk); #1;
      chk("basic_memRd", 32'(o_memRd), 32'd1);
      chk("basic_memAddr", 32'(o_memAddr), 32'h10);
      @(posedge clk); #1;
      chk("basic_valid", 32'(o_instrValid), 32'd1);
      chk("basic_instr", 32'(o_instr), 32'hABCD);
      @(posedge clk); #1;
      chk("basic_incPc", 32'(o_incPc), 32'd1);
      chk("basic_count", 32'(o_fetchCount), 32'd1);
      @(posedge clk); #1;
      chk("basic_incPc_low", 32'(o_incPc), 32'd0);
      @(posedge clk); #1;
      chk("basic_next_memRd", 32'(o_memRd), 32'd1);
      chk("basic_next_addr", 32'(o_memAddr), 32'h11);

      // Back-pressure: five refused HOLD cycles, accepted in the sixth.
      i_decReady = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk("bp_valid", 32'(o_instrValid), 32'd1);
         chk("bp_instr", 32'(o_instr), 32'(mem[8'h11]));
         chk("bp_incPc", 32'(o_incPc), 32'd0);
         if (k == 6) i_decReady = 1'b1;
      end
      @(posedge clk); #1;
      chk("bp_pulse", 32'(o_incPc), 32'd1);
      chk("bp_count", 32'(o_fetchCount), 32'd2);
      @(posedge clk); #1;
      chk("bp_single_pulse", 32'(o_incPc), 32'd0);

      // Flush colliding with ack in the first REQ cycle, PC moved to 0x40.
      @(posedge clk); #1;
      chk("fl_memRd", 32'(o_memRd), 32'd1);
      chk("fl_addr", 32'(o_memAddr), 32'h12);
      i_flush = 1'b1;
      redirect(8'h40);
      @(posedge clk); #1;
      i_flush = 1'b0;
      chk("fl_memRd_drop", 32'(o_memRd), 32'd0);
      chk("fl_valid", 32'(o_instrValid), 32'd0);
      chk("fl_count", 32'(o_fetchCount), 32'd2);
      chk("fl_instr_kept", 32'(o_instr), 32'(mem[8'h11]));
      @(posedge clk); #1;
      chk("fl_refetch_addr", 32'(o_memAddr), 32'h40);
      chk("fl_refetch_rd", 32'(o_memRd), 32'd1);
      @(posedge clk); #1;
      chk("fl_refetch_instr", 32'(o_instr), 32'(mem[8'h40]));

      // Randomised traffic long enough to wrap the accept counter.
      lat_mode = -1;
      cyc = 0;
      while (acc_total < 300 && cyc < 8000) begin
         @(posedge clk); #1;
         cyc++;
         i_decReady = ($urandom_range(3, 0) != 0);
         i_flush    = ($urandom_range(23, 0) == 0);
         if (i_flush) redirect(8'($urandom));
      end
      chk("random_accepts_reached", 32'(acc_total >= 300), 32'd1);
      i_flush    = 1'b0;
      i_decReady = 1'b1;
      lat_mode   = 0;

      // Asynchronous reset in the middle of an ADVANCE cycle.
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (!o_incPc && w < 50);
      chk("adv_reached", 32'(o_incPc), 32'd1);
      #1;
      i_reset = 1'b1;
      #1;
      chk("arst_incPc", 32'(o_incPc), 32'd0);
      chk("arst_memRd", 32'(o_memRd), 32'd0);
      chk("arst_memAddr", 32'(o_memAddr), 32'd0);
      chk("arst_instr", 32'(o_instr), 32'd0);
      chk("arst_valid", 32'(o_instrValid), 32'd0);
      chk("arst_err", 32'(o_fetchErr), 32'd0);
      chk("arst_count", 32'(o_fetchCount), 32'd0);
      @(posedge clk); #1;
      i_reset = 1'b0;
      redirect(8'h80);
      lat_mode = 2;
      chk("rel_idle", 32'(o_memRd), 32'd0);
      @(posedge clk); #1;
      chk("rel_req", 32'(o_memRd), 32'd1);
      chk("rel_addr", 32'(o_memAddr), 32'h80);

      // Ack in the last allowed REQ cycle is still accepted.
      rd_hi = 1;
      for (int k = 0; k < 10 && !o_instrValid; k++) begin
         @(posedge clk); #1;
         if (o_memRd) rd_hi++;
      end
      chk("late_ack_valid", 32'(o_instrValid), 32'd1);
      chk("late_ack_rd_cycles", 32'(rd_hi), 32'(TMO));
      chk("late_ack_no_err", 32'(o_fetchErr), 32'd0);

      // No ack at all: timeout into a sticky error that flush cannot clear.
      ack_en = 1'b0;
      w = 0;
      do begin
         @(posedge clk); #1;
         w++;
      end while (!o_memRd && w < 10);
      chk("tmo_req_seen", 32'(o_memRd), 32'd1);
      rd_hi = 1;
      w = 0;
      while (o_memRd && w < 20) begin
         @(posedge clk); #1;
         w++;
         if (o_memRd) rd_hi++;
      end
      chk("tmo_rd_cycles", 32'(rd_hi), 32'(TMO));
      chk("tmo_err", 32'(o_fetchErr), 32'd1);
      chk("tmo_valid", 32'(o_instrValid), 32'd0);
      i_flush  = 1'b1;
      ack_en   = 1'b1;
      lat_mode = 0;
      @(posedge clk); #1;
      i_flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", 32'(o_fetchErr), 32'd1);
      chk("err_memRd", 32'(o_memRd), 32'd0);
      chk("err_valid", 32'(o_instrValid), 32'd0);
      chk("err_incPc", 32'(o_incPc), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
